// File: rtl/sprite_motion_sequencer.sv
// Per-frame sprite motion controller for the VGA raster.
// On each frame_start the controller visits every sprite slot in turn. Each
// slot goes through one shared bounce/add/clamp datapath and takes exactly
// four cycles: FETCH, BOUNCE, MOVE and NEXT. Between sweeps, slot
// configuration is written over a valid/ready handshake.
module sprite_motion_sequencer #(
  parameter int NUM_SPRITES = 4,
  parameter int IDXW        = 2,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int XW          = 10,
  parameter int YW          = 10,
  parameter int VW          = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_start,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [IDXW-1:0]             cfg_idx,
  input  logic [XW-1:0]               cfg_x,
  input  logic [YW-1:0]               cfg_y,
  input  logic [XW-1:0]               cfg_w,
  input  logic [YW-1:0]               cfg_h,
  input  logic signed [VW-1:0]        cfg_vx,
  input  logic signed [VW-1:0]        cfg_vy,
  input  logic                        cfg_en,
  output logic [NUM_SPRITES*XW-1:0]   obj_x,
  output logic [NUM_SPRITES*YW-1:0]   obj_y,
  output logic [NUM_SPRITES*XW-1:0]   obj_w,
  output logic [NUM_SPRITES*YW-1:0]   obj_h,
  output logic [NUM_SPRITES-1:0]      obj_en,
  output logic                        busy,
  output logic                        update_done,
  output logic                        overrun
);

  // Signed working width. It has two guard bits above the wider position
  // field, so that pos+size+vel can be compared against the raster limit.
  localparam int AW = ((XW > YW) ? XW : YW) + 2;
  localparam logic signed [AW-1:0] H_MAX = AW'(H_ACTIVE - 1);
  localparam logic signed [AW-1:0] V_MAX = AW'(V_ACTIVE - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_SPRITES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, BOUNCE, MOVE, NEXT} state_t;

  state_t          state;
  logic [IDXW-1:0] idx;

  // Slot storage
  logic [XW-1:0]          sx  [NUM_SPRITES];
  logic [YW-1:0]          sy  [NUM_SPRITES];
  logic [XW-1:0]          sw  [NUM_SPRITES];
  logic [YW-1:0]          sh  [NUM_SPRITES];
  logic signed [VW-1:0]   svx [NUM_SPRITES];
  logic signed [VW-1:0]   svy [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] sen;

  // Fetched slot (p0) and post-bounce velocities (p1)
  logic [XW-1:0]        x_p0, w_p0;
  logic [YW-1:0]        y_p0, h_p0;
  logic signed [VW-1:0] vx_p0, vy_p0;
  logic                 en_p0;
  logic signed [VW-1:0] vx_p1, vy_p1;

  logic signed [VW-1:0] bvx, bvy;
  logic [XW-1:0]        nx;
  logic [YW-1:0]        ny;

  function automatic logic signed [AW-1:0] ext_ux(input logic [XW-1:0] v);
    return signed'({{(AW-XW){1'b0}}, v});
  endfunction

  function automatic logic signed [AW-1:0] ext_uy(input logic [YW-1:0] v);
    return signed'({{(AW-YW){1'b0}}, v});
  endfunction

  function automatic logic signed [AW-1:0] ext_v(input logic signed [VW-1:0] v);
    return signed'({{(AW-VW){v[VW-1]}}, v});
  endfunction

  // Magnitude of a velocity. The most negative value saturates to the
  // largest positive value, because its true magnitude does not fit.
  function automatic logic signed [VW-1:0] abs_sat(input logic signed [VW-1:0] v);
    if (v == {1'b1, {(VW-1){1'b0}}}) return {1'b0, {(VW-1){1'b1}}};
    else if (v < 0)                  return -v;
    else                             return v;
  endfunction

  // Point the velocity away from whichever edge the next step would cross
  function automatic logic signed [VW-1:0] bounce_vel(
    input logic signed [AW-1:0] pos,
    input logic signed [AW-1:0] size,
    input logic signed [VW-1:0] v,
    input logic signed [AW-1:0] lim
  );
    logic signed [AW-1:0] sum;
    sum = pos + ext_v(v);
    if (sum < 0)              return abs_sat(v);
    else if (sum + size > lim) return -abs_sat(v);
    else                       return v;
  endfunction

  // Saturate the stepped position so the sprite stays fully on screen.
  // A sprite wider than the raster is pinned to 0.
  function automatic logic signed [AW-1:0] clamp_pos(
    input logic signed [AW-1:0] pos,
    input logic signed [AW-1:0] size,
    input logic signed [VW-1:0] v,
    input logic signed [AW-1:0] lim
  );
    logic signed [AW-1:0] n;
    logic signed [AW-1:0] hi;
    n  = pos + ext_v(v);
    hi = lim - size;
    if (size > lim) return '0;
    if (n < 0)      return '0;
    if (n > hi)     return hi;
    return n;
  endfunction

  assign bvx = bounce_vel(ext_ux(x_p0), ext_ux(w_p0), vx_p0, H_MAX);
  assign bvy = bounce_vel(ext_uy(y_p0), ext_uy(h_p0), vy_p0, V_MAX);
  assign nx  = XW'(clamp_pos(ext_ux(x_p0), ext_ux(w_p0), vx_p1, H_MAX));
  assign ny  = YW'(clamp_pos(ext_uy(y_p0), ext_uy(h_p0), vy_p1, V_MAX));

  assign cfg_ready = (state == IDLE) && !frame_start && !reset;

  // Flatten slot storage onto the renderer-facing buses
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_flat
    assign obj_x[g*XW +: XW] = sx[g];
    assign obj_y[g*YW +: YW] = sy[g];
    assign obj_w[g*XW +: XW] = sw[g];
    assign obj_h[g*YW +: YW] = sh[g];
  end
  assign obj_en = sen;

  // Sweep FSM, slot storage, config writes and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      update_done <= 1'b0;
      overrun     <= 1'b0;
      sen         <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sx[i]  <= '0;
        sy[i]  <= '0;
        sw[i]  <= '0;
        sh[i]  <= '0;
        svx[i] <= '0;
        svy[i] <= '0;
      end
    end else begin
      update_done <= 1'b0;
      overrun     <= frame_start && (state != IDLE);
      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= FETCH;
            busy  <= 1'b1;
            idx   <= '0;
          end else if (cfg_valid && cfg_ready) begin
            sx[cfg_idx]  <= cfg_x;
            sy[cfg_idx]  <= cfg_y;
            sw[cfg_idx]  <= cfg_w;
            sh[cfg_idx]  <= cfg_h;
            svx[cfg_idx] <= cfg_vx;
            svy[cfg_idx] <= cfg_vy;
            sen[cfg_idx] <= cfg_en;
          end
        end
        // stage p0: fetch slot into working registers
        FETCH: begin
          x_p0  <= sx[idx];
          y_p0  <= sy[idx];
          w_p0  <= sw[idx];
          h_p0  <= sh[idx];
          vx_p0 <= svx[idx];
          vy_p0 <= svy[idx];
          en_p0 <= sen[idx];
          state <= BOUNCE;
        end
        // stage p1: edge bounce on velocities
        BOUNCE: begin
          vx_p1 <= bvx;
          vy_p1 <= bvy;
          state <= MOVE;
        end
        // stage p2: step, clamp, write back enabled slots
        MOVE: begin
          if (en_p0) begin
            sx[idx]  <= nx;
            sy[idx]  <= ny;
            svx[idx] <= vx_p1;
            svy[idx] <= vy_p1;
          end
          state <= NEXT;
        end
        NEXT: begin
          if (idx == LAST_IDX) begin
            busy        <= 1'b0;
            update_done <= 1'b1;
            state       <= IDLE;
          end else begin
            idx   <= idx + 1'b1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion_sequencer.sv
// Directed testbench for sprite_motion_sequencer.
module tb_sprite_motion_sequencer;

  localparam int NS = 4;
  localparam int IDXW = 2;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int VW = 8;

  logic clk = 1'b0;
  logic reset, frame_start, cfg_valid, cfg_ready, cfg_en;
  logic [IDXW-1:0] cfg_idx;
  logic [XW-1:0] cfg_x, cfg_w;
  logic [YW-1:0] cfg_y, cfg_h;
  logic signed [VW-1:0] cfg_vx, cfg_vy;
  logic [NS*XW-1:0] obj_x, obj_w;
  logic [NS*YW-1:0] obj_y, obj_h;
  logic [NS-1:0] obj_en;
  logic busy, update_done, overrun;

  int tests = 0;
  int failed = 0;

  sprite_motion_sequencer dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_vx(cfg_vx), .cfg_vy(cfg_vy), .cfg_en(cfg_en),
    .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h),
    .obj_en(obj_en), .busy(busy), .update_done(update_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [XW-1:0] ox(input int i);
    return obj_x[i*XW +: XW];
  endfunction
  function automatic logic [YW-1:0] oy(input int i);
    return obj_y[i*YW +: YW];
  endfunction
  function automatic logic [XW-1:0] ow(input int i);
    return obj_w[i*XW +: XW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int idx, input int x, input int y, input int w,
                         input int h, input int vx, input int vy, input bit en);
    cfg_idx = IDXW'(idx);
    cfg_x = XW'(x); cfg_y = YW'(y); cfg_w = XW'(w); cfg_h = YW'(h);
    cfg_vx = VW'(vx); cfg_vy = VW'(vy); cfg_en = en;
  endtask

  // Handshake one config write (bounded)
  task automatic cfg_write(input int idx, input int x, input int y, input int w,
                           input int h, input int vx, input int vy, input bit en);
    int k;
    set_cfg(idx, x, y, w, h, vx, vy, en);
    cfg_valid = 1'b1;
    k = 0;
    while (!cfg_ready && k < 50) begin tick(); k++; end
    if (k >= 50) begin
      $display("FAIL cfg_write_timeout: cfg_ready stayed %0b, required 1", cfg_ready);
      failed++; tests++;
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  // Pulse frame_start; return edges from the frame_start edge to update_done
  task automatic run_frame(output int n, output int busy_cnt);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    busy_cnt = busy ? 1 : 0;
    while (!update_done && n < 40) begin
      tick(); n++;
      if (busy) busy_cnt++;
    end
    if (n >= 40) begin
      $display("FAIL frame_timeout: update_done not seen in 40 cycles, required by 16");
      failed++; tests++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    tests++;
    if (busy !== 1'b0 || update_done !== 1'b0 || overrun !== 1'b0) begin
      $display("FAIL reset_status: busy=%b done=%b ovr=%b, required 0 0 0", busy, update_done, overrun);
      failed++;
    end
    tests++;
    if (cfg_ready !== 1'b0) begin
      $display("FAIL reset_cfg_ready: got %b required 0", cfg_ready); failed++;
    end
    tests++;
    if (obj_x !== '0 || obj_y !== '0 || obj_w !== '0 || obj_h !== '0 || obj_en !== '0) begin
      $display("FAIL reset_obj: x=%h y=%h w=%h h=%h en=%b, required all 0", obj_x, obj_y, obj_w, obj_h, obj_en);
      failed++;
    end
    reset = 1'b0;
    tick();
    tests++;
    if (cfg_ready !== 1'b1) begin
      $display("FAIL idle_cfg_ready: got %b required 1", cfg_ready); failed++;
    end
  endtask

  task automatic test_basic_move();
    int n, bc;
    cfg_write(0, 100, 50, 20, 20, -5, 4, 1'b1);
    tests++;
    if (ox(0) !== 10'd100 || oy(0) !== 10'd50 || obj_en[0] !== 1'b1) begin
      $display("FAIL cfg_accept: x=%0d y=%0d en=%b, required 100 50 1", ox(0), oy(0), obj_en[0]);
      failed++;
    end
    run_frame(n, bc);
    tests++;
    if (n !== 16) begin
      $display("FAIL done_latency: got %0d required 16", n); failed++;
    end
    tests++;
    if (bc !== 16) begin
      $display("FAIL busy_cycles: got %0d required 16", bc); failed++;
    end
    tests++;
    if (ox(0) !== 10'd95 || oy(0) !== 10'd54) begin
      $display("FAIL basic_move: x=%0d y=%0d, required 95 54", ox(0), oy(0)); failed++;
    end
    tick();
    tests++;
    if (update_done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL done_pulse_width: done=%b busy=%b, required 0 0", update_done, busy); failed++;
    end
  endtask

  task automatic test_bounce();
    int n, bc;
    cfg_write(0, 2, 50, 20, 20, -5, 0, 1'b1);
    run_frame(n, bc);
    tests++;
    if (ox(0) !== 10'd7) begin
      $display("FAIL bounce_left: x=%0d required 7", ox(0)); failed++;
    end
    run_frame(n, bc);
    tests++;
    if (ox(0) !== 10'd12) begin
      $display("FAIL bounce_left_vel: x=%0d required 12", ox(0)); failed++;
    end
    cfg_write(0, 615, 50, 20, 20, 5, 0, 1'b1);
    run_frame(n, bc);
    tests++;
    if (ox(0) !== 10'd610) begin
      $display("FAIL bounce_right: x=%0d required 610", ox(0)); failed++;
    end
    run_frame(n, bc);
    tests++;
    if (ox(0) !== 10'd605) begin
      $display("FAIL bounce_right_vel: x=%0d required 605", ox(0)); failed++;
    end
  endtask

  task automatic test_clamp();
    int n, bc;
    cfg_write(1, 10, 478, 10, 20, 0, 0, 1'b1);
    cfg_write(2, 10, 10, 700, 10, 0, 0, 1'b1);
    tests++;
    if (ow(2) !== 10'd700 || oy(1) !== 10'd478) begin
      $display("FAIL cfg_no_clamp: w2=%0d y1=%0d, required 700 478", ow(2), oy(1)); failed++;
    end
    run_frame(n, bc);
    tests++;
    if (oy(1) !== 10'd459 || ox(1) !== 10'd10) begin
      $display("FAIL clamp_y: x1=%0d y1=%0d, required 10 459", ox(1), oy(1)); failed++;
    end
    tests++;
    if (ox(2) !== 10'd0 || oy(2) !== 10'd10) begin
      $display("FAIL wide_sprite: x2=%0d y2=%0d, required 0 10", ox(2), oy(2)); failed++;
    end
  endtask

  task automatic test_cfg_during_sweep();
    int low_cnt, ov_cnt, ov_at, done_at, acc_at;
    low_cnt = 0; ov_cnt = 0; ov_at = -1; done_at = -1; acc_at = -1;
    set_cfg(3, 300, 200, 16, 16, 10, 0, 1'b0);
    cfg_valid = 1'b1;
    frame_start = 1'b1;
    #1;
    if (!cfg_ready) low_cnt++;
    for (int k = 0; k <= 17; k++) begin
      tick();
      if (k == 0) frame_start = 1'b0;
      if (k == 4) frame_start = 1'b1;
      if (k == 5) frame_start = 1'b0;
      if (k == 16) begin
        tests++;
        if (ox(3) !== 10'd0) begin
          $display("FAIL cfg_early_write: x3=%0d required 0", ox(3)); failed++;
        end
      end
      if (overrun) begin ov_cnt++; ov_at = k; end
      if (update_done && done_at < 0) done_at = k;
      if (cfg_valid && acc_at >= 0) cfg_valid = 1'b0;
      if (cfg_valid) begin
        if (!cfg_ready) low_cnt++;
        else acc_at = k;
      end
    end
    cfg_valid = 1'b0;
    tests++;
    if (low_cnt !== 17) begin
      $display("FAIL cfg_ready_low: got %0d cycles required 17", low_cnt); failed++;
    end
    tests++;
    if (ov_cnt !== 1 || ov_at !== 5) begin
      $display("FAIL overrun: count=%0d at=%0d, required 1 at 5", ov_cnt, ov_at); failed++;
    end
    tests++;
    if (done_at !== 16) begin
      $display("FAIL overrun_done: got %0d required 16", done_at); failed++;
    end
    tests++;
    if (ox(3) !== 10'd300 || oy(3) !== 10'd200 || obj_en[3] !== 1'b0) begin
      $display("FAIL held_cfg_write: x3=%0d y3=%0d en3=%b, required 300 200 0", ox(3), oy(3), obj_en[3]);
      failed++;
    end
  endtask

  task automatic test_disabled();
    int n, bc;
    repeat (3) run_frame(n, bc);
    tests++;
    if (ox(3) !== 10'd300 || oy(3) !== 10'd200) begin
      $display("FAIL disabled_slot: x3=%0d y3=%0d, required 300 200", ox(3), oy(3)); failed++;
    end
  endtask

  task automatic test_vx_min();
    int n, bc;
    cfg_write(1, 0, 100, 10, 10, -128, 0, 1'b1);
    run_frame(n, bc);
    tests++;
    if (ox(1) !== 10'd127) begin
      $display("FAIL vx_min: x1=%0d required 127", ox(1)); failed++;
    end
    run_frame(n, bc);
    tests++;
    if (ox(1) !== 10'd254 || oy(1) !== 10'd100) begin
      $display("FAIL vx_min_vel: x1=%0d y1=%0d, required 254 100", ox(1), oy(1)); failed++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    int done_seen;
    done_seen = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (update_done) done_seen++;
    end
    tests++;
    if (busy !== 1'b1) begin
      $display("FAIL mid_sweep_busy: got %b required 1", busy); failed++;
    end
    reset = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || obj_x !== '0 || obj_y !== '0 || obj_w !== '0 || obj_h !== '0 || obj_en !== '0) begin
      $display("FAIL mid_reset_state: busy=%b x=%h y=%h en=%b, required 0 0 0 0", busy, obj_x, obj_y, obj_en);
      failed++;
    end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (update_done) done_seen++;
    end
    tests++;
    if (done_seen !== 0 || busy !== 1'b0) begin
      $display("FAIL mid_reset_done: pulses=%0d busy=%b, required 0 0", done_seen, busy); failed++;
    end
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 1'b0);
    test_reset();
    test_basic_move();
    test_bounce();
    test_clamp();
    test_cfg_during_sweep();
    test_disabled();
    test_vx_min();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
